// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART console transmitter:
// FSM state encoding, default bus addresses and status-register bit layout.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } TxState;

  localparam logic [7:0] DEFAULT_TX_ADDR     = 8'hFF;
  localparam logic [7:0] DEFAULT_STATUS_ADDR = 8'hFE;

  // Status register bit positions
  localparam int unsigned STATUS_BUSY     = 0;
  localparam int unsigned STATUS_EMPTY    = 1;
  localparam int unsigned STATUS_FULL     = 2;
  localparam int unsigned STATUS_OVERFLOW = 3;
  localparam int unsigned STATUS_WIDTH    = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MEM-stage data-store bus as seen by memory-mapped peripherals.
//   mem_wren    : store enable
//   mem_addr    : low byte of the data address
//   mem_data    : store data
//   status_data : peripheral read-back word (combinational)
// master = core side, slave = peripheral side.
interface mmio_uart_tx_if;
  logic        mem_wren;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] status_data;

  modport master (
    output mem_wren,
    output mem_addr,
    output mem_data,
    input  status_data
  );

  modport slave (
    input  mem_wren,
    input  mem_addr,
    input  mem_data,
    output status_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO with occupancy count.
//   clock, clear (async active-low)
//   push/wrData : enqueue (ignored when full)
//   pop/rdData  : dequeue head (ignored when empty); rdData shows current head
//   full, empty, count (0..DEPTH)
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic [7:0]               wrData,
  input  logic                     pop,
  output logic [7:0]               rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  // Storage array, no reset needed: validity is tracked by the pointers
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter snooping MEM-stage stores.
//   clock, clear (async active-low)
//   bus         : store bus; bytes stored to TX_ADDR are queued, stores to
//                 STATUS_ADDR with data[0]=1 clear overflow; status_data reads
//                 {overflow, full, empty, busy} when addressed, else 0
//   tx          : 8N1 serial output, LSB first, idle high
//   busy        : frame in progress or bytes queued
//   fifo_count  : queued bytes
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  TX_ADDR      = DEFAULT_TX_ADDR,
  parameter logic [7:0]  STATUS_ADDR  = DEFAULT_STATUS_ADDR
) (
  input  logic                          clock,
  input  logic                          clear,
  mmio_uart_tx_if.slave                 bus,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  TxState              state;
  logic [BAUD_W-1:0]   baudCnt;
  logic [2:0]          bitIdx;
  logic [7:0]          shiftReg;
  logic                overflow;

  logic                pushReq;
  logic                clrReq;
  logic                pushEn;
  logic                popEn;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [7:0]          fifoRdData;
  logic                baudLast;
  logic [STATUS_WIDTH-1:0] statusBits;
  logic                unusedData;

  // Address decode; only the low byte of a store is queued
  assign pushReq    = bus.mem_wren && (bus.mem_addr == TX_ADDR);
  assign clrReq     = bus.mem_wren && (bus.mem_addr == STATUS_ADDR) && bus.mem_data[0];
  assign pushEn     = pushReq && !fifoFull;
  assign popEn      = (state == IDLE) && !fifoEmpty;
  assign baudLast   = (baudCnt == BAUD_LAST);
  assign unusedData = ^bus.mem_data[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clock  (clock),
    .clear  (clear),
    .push   (pushEn),
    .wrData (bus.mem_data[7:0]),
    .pop    (popEn),
    .rdData (fifoRdData),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifo_count)
  );

  // Decoded straight from state and FIFO registers
  assign busy = (state != IDLE) || !fifoEmpty;

  // Status read-back
  always_comb begin
    statusBits                  = '0;
    statusBits[STATUS_BUSY]     = busy;
    statusBits[STATUS_EMPTY]    = fifoEmpty;
    statusBits[STATUS_FULL]     = fifoFull;
    statusBits[STATUS_OVERFLOW] = overflow;
  end

  assign bus.status_data = (bus.mem_addr == STATUS_ADDR) ? 32'(statusBits) : 32'd0;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      overflow <= 1'b0;
    end else if (pushReq && fifoFull) begin
      overflow <= 1'b1;
    end else if (clrReq) begin
      overflow <= 1'b0;
    end
  end

  // Serialiser: tx is registered and loaded with the level of the next phase
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (popEn) begin
            shiftReg <= fifoRdData;
            baudCnt  <= '0;
            state    <= START;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (baudLast) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            state   <= DATA;
            tx      <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baudLast) begin
            baudCnt  <= '0;
            shiftReg <= shiftReg >> 1;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              tx     <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baudLast) begin
            baudCnt <= '0;
            state   <= IDLE;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a timeline model predicts accepted bytes,
// their frame start cycles, occupancy, busy and status; an independent line
// monitor decodes frames from tx and checks them against the expected queue.
module tb_mmio_uart_tx;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * N;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       tx;
  logic       busy;
  logic [3:0] fifoCount;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (8'hFF),
    .STATUS_ADDR  (8'hFE)
  ) dut (
    .clock      (clk),
    .clear      (clear),
    .bus        (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifoCount)
  );

  always #5 clk = ~clk;

  // Edge index: value k is visible after the k-th rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmpCount = 0;
  int errCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (timeline of accepted bytes) -------------
  typedef struct {
    logic [7:0] data;
    int         startEdge;
  } ExpFrame;

  ExpFrame expQ[$];
  int      pushE[$];
  int      popE[$];
  int      lastPop = -100000;
  bit      ovf = 1'b0;

  function automatic int countAfter(input int c);
    int n = 0;
    foreach (pushE[i]) if (pushE[i] <= c) n++;
    foreach (popE[i])  if (popE[i]  <= c) n--;
    return n;
  endfunction

  function automatic bit sendingAfter(input int c);
    foreach (popE[i]) if (popE[i] <= c && c < popE[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] expStatus(input int c, input logic [7:0] addr);
    int n = countAfter(c);
    bit b = sendingAfter(c) || (n > 0);
    if (addr != 8'hFE) return 32'd0;
    return {28'd0, ovf, 1'(n == DEPTH), 1'(n == 0), b};
  endfunction

  // Apply a bus cycle sampled at edge e to the model
  task automatic modelStore(input logic w, input logic [7:0] a, input logic [31:0] d, input int e);
    int p;
    if (!w) return;
    if (a == 8'hFF) begin
      if (countAfter(e - 1) >= DEPTH) begin
        ovf = 1'b1;
      end else begin
        // Transmitter frees one idle cycle after the previous frame ends
        p = (e + 1 > lastPop + FRAME + 1) ? e + 1 : lastPop + FRAME + 1;
        pushE.push_back(e);
        popE.push_back(p);
        lastPop = p;
        expQ.push_back('{data: d[7:0], startEdge: p});
      end
    end else if (a == 8'hFE && d[0]) begin
      ovf = 1'b0;
    end
  endtask

  task automatic modelFlush();
    pushE.delete();
    popE.delete();
    expQ.delete();
    lastPop = -100000;
    ovf = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  task automatic busCycle(input logic w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_wren = w;
    bus.mem_addr = a;
    bus.mem_data = d;
    #1;
    check("fifo_count", 32'(fifoCount), 32'(countAfter(cyc)));
    check("busy", 32'(busy), 32'(sendingAfter(cyc) || countAfter(cyc) > 0));
    check("status_data", bus.status_data, expStatus(cyc, a));
    modelStore(w, a, d, cyc + 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((expQ.size() != 0 || cyc <= lastPop + FRAME + 1) && k < 5000) begin
      busCycle(1'b0, 8'hFE, 32'd0);
      k++;
    end
    check("drain_outstanding_frames", 32'(expQ.size()), 32'd0);
  endtask

  // ---------------- line monitor ----------------
  task automatic decodeFrame();
    int         startC = cyc;
    logic [9:0] bits = '0;
    bit         stable = 1'b1;
    ExpFrame    e;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (!clear) return;
      if (k % N == 0) bits[k / N] = tx;
      else if (tx !== bits[k / N]) stable = 1'b0;
    end
    if (expQ.size() == 0) begin
      cmpCount++;
      errCount++;
      $display("FAIL unexpected_frame @cycle %0d: got byte %0h, required no frame", startC, bits[8:1]);
      return;
    end
    e = expQ.pop_front();
    check("frame_start_cycle", 32'(startC), 32'(e.startEdge));
    check("frame_data", 32'(bits[8:1]), 32'(e.data));
    check("frame_start_stop_stable", 32'({bits[9], bits[0], stable}), 32'b101);
  endtask

  initial begin
    logic prevTx = 1'b1;
    forever begin
      @(negedge clk);
      if (clear && prevTx === 1'b1 && tx === 1'b0) decodeFrame();
      prevTx = tx;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int s;
    int r;
    bus.mem_wren = 1'b0;
    bus.mem_addr = 8'hFE;
    bus.mem_data = 32'd0;

    // Reset held three cycles; status reads empty only
    repeat (3) busCycle(1'b0, 8'hFE, 32'd0);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_status", bus.status_data, 32'h2);
    @(negedge clk);
    clear = 1'b1;
    busCycle(1'b0, 8'hFE, 32'd0);

    // Single byte
    busCycle(1'b1, 8'hFF, 32'h0000_0041);
    drain();

    // Back-to-back frames
    busCycle(1'b1, 8'hFF, 32'h48);
    busCycle(1'b1, 8'hFF, 32'h69);
    busCycle(1'b1, 8'hFF, 32'h0A);
    drain();

    // Overflow and clear
    for (int i = 0; i < 10; i++) busCycle(1'b1, 8'hFF, 32'(8'h30 + i));
    busCycle(1'b0, 8'hFE, 32'd0);
    check("overflow_status", bus.status_data, 32'hD);
    busCycle(1'b1, 8'hFE, 32'h1);
    busCycle(1'b0, 8'hFE, 32'd0);
    drain();

    // Address filter
    busCycle(1'b1, 8'h10, 32'h55);
    busCycle(1'b1, 8'hFD, 32'h55);
    repeat (3) busCycle(1'b0, 8'h10, 32'd0);
    check("filter_tx_idle", 32'(tx), 32'd1);

    // Reset during data bit 3 with two bytes queued
    busCycle(1'b1, 8'hFF, 32'h41);
    s = expQ[0].startEdge;
    busCycle(1'b1, 8'hFF, 32'h42);
    busCycle(1'b1, 8'hFF, 32'h43);
    while (cyc < s + 4 * N + 1) busCycle(1'b0, 8'hFE, 32'd0);
    check("bit3_low_before_reset", 32'(tx), 32'd0);
    check("queued_before_reset", 32'(fifoCount), 32'd2);
    clear = 1'b0;
    #1;
    modelFlush();
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_count", 32'(fifoCount), 32'd0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    repeat (100) busCycle(1'b0, 8'hFE, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        for (int j = 0; j < 12; j++) busCycle(1'b1, 8'hFF, $urandom());
      end else if (r < 35) busCycle(1'b1, 8'hFF, $urandom());
      else if (r < 42) busCycle(1'b1, 8'hFE, $urandom());
      else if (r < 50) busCycle(1'b1, 8'($urandom()), $urandom());
      else busCycle(1'b0, (r < 75) ? 8'hFE : 8'($urandom()), $urandom());
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped console transmitter hanging off the core's MEM-stage data-store bus, downstream of the pipeline.
- Snoops every store the core issues to data memory.
- Stores to the TX address are captured into a small FIFO and serialised on a UART line (8N1, LSB first).
- A status address exposes busy, empty, full and overflow state to software.
- Replaces the bench practice of watching the last data-memory word for character output.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
FIFO_DEPTH, 8, byte entries in TX FIFO (power of 2, >=2)
TX_ADDR, 8'hFF, store address that enqueues a byte
STATUS_ADDR, 8'hFE, store/read address of status register

Ports:
clock  in  1  core clock, rising edge
clear  in  1  asynchronous active-low reset
mem_wren  in  1  MEM-stage store enable
mem_addr  in  8  MEM-stage data address (low byte of ALU result)
mem_data  in  32  MEM-stage store data
status_data  out  32  {28'b0, overflow, full, empty, busy}; driven only when mem_addr==STATUS_ADDR, else 0 (combinational)
tx  out  1  serial output, idle high
busy  out  1  FSM not in IDLE or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset (clear low, async): tx=1, state IDLE, FIFO empty, fifo_count=0, overflow=0, busy=0, shift register and counters 0. Reset mid-frame aborts the frame immediately; queued bytes are lost.
- Push:
  - mem_wren && mem_addr==TX_ADDR at a rising edge enqueues mem_data[7:0]; upper bits are ignored (sb and sw behave identically).
  - Full is evaluated on pre-edge state. If full, the byte is dropped and overflow sets (sticky), even if a pop occurs the same cycle.
- Status write: mem_wren && mem_addr==STATUS_ADDR && mem_data[0]==1 clears overflow. If a clear and a new overflow coincide, set wins.
- Other addresses: no effect.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty at an edge: pop head into shift reg, baud counter=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; a state/bit advances when counter==CLKS_PER_BIT-1.
- Latency:
  - Store sampled at edge E0 makes the FIFO non-empty.
  - Pop at E1; tx falls after E1.
  - Frame is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly one extra idle-high cycle (the IDLE state).
- Simultaneous push and pop when not full: both occur, count unchanged. A push to an empty FIFO is not visible to the pop until the next edge.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- tx is registered (no glitches).

Decomposition:
- Shared package mmio_pkg:
  - FSM state encoding (IDLE/START/DATA/STOP, 2 bits)
  - default TX_ADDR and STATUS_ADDR constants
  - status bit positions (BUSY=0, EMPTY=1, FULL=2, OVERFLOW=3)
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count, async active-low clear, parameter DEPTH, width 8. The top module holds the FSM, baud counter, address decode and overflow flag.

Test Plan:
- Reset: hold clear low 3 cycles, CLKS_PER_BIT=4 -> tx=1, busy=0, status_data at 0xFE = 32'h2 (empty), fifo_count=0.
- Single byte: sw 0x00000041 to 0xFF -> tx low starting 1 cycle after store edge for 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, stop high 4 cycles; busy falls after 40 cycles.
- Back-to-back: store 'H','i',0x0A on consecutive cycles -> three frames in order, each 40 cycles, separated by one idle-high cycle; fifo_count peaks at 2.
- Overflow: DEPTH=8, 10 consecutive stores 0x30..0x39 -> 0x39 dropped, overflow=1 (status 32'hC plus busy bit = 32'hD); sw 0x1 to 0xFE clears overflow; exactly 0x30..0x38 are transmitted.
- Address filter: sw 0x55 to 0x10 and 0xFD -> tx stays high, fifo_count=0; read at 0x10 gives status_data=0.
- Reset mid-frame: assert clear during DATA bit 3 of 0x41 with 2 bytes queued -> tx=1 immediately (async), fifo_count=0, no further frames after release.
